sm83_alu_nibble: RTL and testbench

SM83_ALU_NIBBLE -- requirements
Module: sm83_alu_nibble

---
 rtl/sm83_alu_pkg.sv | 48 ++++
 rtl/sm83_alu_nibble_if.sv | 41 ++++
 rtl/sm83_alu_slice4.sv | 29 ++
 rtl/sm83_alu_nibble.sv | 177 +++++++++++++++++
 tb/tb_sm83_alu_nibble.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sm83_alu_pkg.sv
// Shared types for the SM83 nibble-serial ALU: opcodes, FSM states, slice modes,
// the latched request record and the DAA adjust constants.
package sm83_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADC   = 4'd1,
    OP_SUB   = 4'd2,
    OP_SBC   = 4'd3,
    OP_AND   = 4'd4,
    OP_XOR   = 4'd5,
    OP_OR    = 4'd6,
    OP_CP    = 4'd7,
    OP_SHIFT = 4'd8,
    OP_DAA   = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SL_ADD = 3'd0,
    SL_SUB = 3'd1,
    SL_AND = 3'd2,
    SL_XOR = 3'd3,
    SL_OR  = 3'd4
  } slice_mode_e;

  localparam logic [7:0] DAA_ADJ_L = 8'h06;
  localparam logic [7:0] DAA_ADJ_H = 8'h60;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       carry_in;
    logic       shift_l;
    logic       shift_r;
    logic       shift_in;
    logic [7:0] daa_out;
    logic       daa_carry;
    logic       n_in;
  } alu_req_t;

endpackage

// File: rtl/sm83_alu_nibble_if.sv
// Request/result bus of the SM83 nibble ALU; master drives operands, slave returns results.
interface sm83_alu_nibble_if;
  logic       start;
  logic [3:0] alu_op;
  logic [7:0] a;
  logic [7:0] b;
  logic       carry_in;
  logic       shift_l;
  logic       shift_r;
  logic       shift_into_alu;
  logic [7:0] daa_out;
  logic       daa_carry_out;
  logic       n_in;
  logic       busy;
  logic       valid;
  logic [7:0] result;
  logic       flag_z;
  logic       flag_n;
  logic       flag_h;
  logic       flag_c;
  logic       pri_carry;
  logic       shift_dbh;
  logic       shift_dbl;
  logic       daa_l_gt_9;
  logic       daa_h_gt_9;
  logic       daa_h_eq_9;

  modport master (
    output start, alu_op, a, b, carry_in, shift_l, shift_r, shift_into_alu,
           daa_out, daa_carry_out, n_in,
    input  busy, valid, result, flag_z, flag_n, flag_h, flag_c, pri_carry,
           shift_dbh, shift_dbl, daa_l_gt_9, daa_h_gt_9, daa_h_eq_9
  );

  modport slave (
    input  start, alu_op, a, b, carry_in, shift_l, shift_r, shift_into_alu,
           daa_out, daa_carry_out, n_in,
    output busy, valid, result, flag_z, flag_n, flag_h, flag_c, pri_carry,
           shift_dbh, shift_dbl, daa_l_gt_9, daa_h_gt_9, daa_h_eq_9
  );
endinterface

// File: rtl/sm83_alu_slice4.sv
// Combinational 4-bit add/sub/logic slice. For SL_SUB, cin/cout are borrow-in/borrow-out.
module sm83_alu_slice4
  import sm83_alu_pkg::*;
(
  input  logic [3:0]  a,
  input  logic [3:0]  b,
  input  logic        cin,
  input  slice_mode_e mode,
  output logic [3:0]  y,
  output logic        cout
);
  logic       sub;
  logic [4:0] sum;

  // Subtract as a + ~b + ~borrow; the inverted carry out is the borrow.
  assign sub = (mode == SL_SUB);
  assign sum = {1'b0, a} + {1'b0, b ^ {4{sub}}} + {4'b0, cin ^ sub};

  always_comb begin
    y    = sum[3:0];
    cout = sum[4] ^ sub;
    case (mode)
      SL_AND:  begin y = a & b; cout = 1'b0; end
      SL_XOR:  begin y = a ^ b; cout = 1'b0; end
      SL_OR:   begin y = a | b; cout = 1'b0; end
      default: ;
    endcase
  end
endmodule

// File: rtl/sm83_alu_nibble.sv
// SM83 ALU computing 8-bit results as two serial nibbles (IDLE -> LOW -> HIGH).
// Optional DAA support is enabled with `define SM83_ALU_DAA_EN.
module sm83_alu_nibble
  import sm83_alu_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  sm83_alu_nibble_if.slave  bus
);
  state_e      state, state_nxt;
  alu_req_t    req_d, req_q;
  logic [3:0]  lo_q;
  logic        hc_q;
  logic        valid_q;
  logic [7:0]  res_q;
  logic        fz, fn, fh, fc;

  logic        is_daa, is_shift, use_slice, hi;
  slice_mode_e mode;
  logic        cb_in0;
  logic [7:0]  b_eff;
  logic [3:0]  sl_a, sl_b, sl_y, nib;
  logic        sl_cin, sl_cout;
  logic [7:0]  sh_res;
  logic        sh_c;
  logic [7:0]  full, res_nxt;
  logic        z_nxt, n_nxt, h_nxt, c_nxt;

  assign req_d = '{op: bus.alu_op, a: bus.a, b: bus.b, carry_in: bus.carry_in,
                   shift_l: bus.shift_l, shift_r: bus.shift_r, shift_in: bus.shift_into_alu,
                   daa_out: bus.daa_out, daa_carry: bus.daa_carry_out, n_in: bus.n_in};

`ifdef SM83_ALU_DAA_EN
  assign is_daa         = (req_q.op == OP_DAA);
  assign bus.daa_l_gt_9 = (bus.a[3:0] > 4'd9);
  assign bus.daa_h_gt_9 = (bus.a[7:4] > 4'd9);
  assign bus.daa_h_eq_9 = (bus.a[7:4] == 4'd9);
`else
  assign is_daa         = 1'b0;
  assign bus.daa_l_gt_9 = 1'b0;
  assign bus.daa_h_gt_9 = 1'b0;
  assign bus.daa_h_eq_9 = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOW;
      LOW:     state_nxt = HIGH;
      HIGH:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slice configuration derived from the latched opcode; DAA reuses the adder.
  always_comb begin
    mode   = SL_ADD;
    cb_in0 = 1'b0;
    b_eff  = req_q.b;
    case (req_q.op)
      OP_ADC:        cb_in0 = req_q.carry_in;
      OP_SUB, OP_CP: mode = SL_SUB;
      OP_SBC:        begin mode = SL_SUB; cb_in0 = req_q.carry_in; end
      OP_AND:        mode = SL_AND;
      OP_XOR:        mode = SL_XOR;
      OP_OR:         mode = SL_OR;
      default:       ;
    endcase
    if (is_daa) begin
      b_eff = req_q.daa_out;
      mode  = req_q.n_in ? SL_SUB : SL_ADD;
    end
  end

  assign hi     = (state == HIGH);
  assign sl_a   = hi ? req_q.a[7:4] : req_q.a[3:0];
  assign sl_b   = hi ? b_eff[7:4]   : b_eff[3:0];
  assign sl_cin = hi ? hc_q         : cb_in0;

  sm83_alu_slice4 u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (sl_cin),
    .mode (mode),
    .y    (sl_y),
    .cout (sl_cout)
  );

  always_comb begin
    sh_res = req_q.a;
    sh_c   = 1'b0;
    if (req_q.shift_l) begin
      sh_res = {req_q.a[6:0], req_q.shift_in};
      sh_c   = req_q.a[7];
    end else if (req_q.shift_r) begin
      sh_res = {req_q.shift_in, req_q.a[7:1]};
      sh_c   = req_q.a[0];
    end
  end

  assign is_shift  = (req_q.op == OP_SHIFT);
  assign use_slice = (req_q.op < 4'd8) || is_daa;
  assign nib       = use_slice ? sl_y :
                     is_shift  ? (hi ? sh_res[7:4] : sh_res[3:0]) :
                                 (hi ? req_q.a[7:4] : req_q.a[3:0]);
  assign full      = {nib, lo_q};

  always_comb begin
    res_nxt = full;
    z_nxt   = (full == 8'h00);
    n_nxt   = 1'b0;
    h_nxt   = 1'b0;
    c_nxt   = 1'b0;
    case (req_q.op)
      OP_ADD, OP_ADC: begin h_nxt = hc_q; c_nxt = sl_cout; end
      OP_SUB, OP_SBC: begin n_nxt = 1'b1; h_nxt = hc_q; c_nxt = sl_cout; end
      OP_CP:          begin res_nxt = req_q.a; n_nxt = 1'b1; h_nxt = hc_q; c_nxt = sl_cout; end
      OP_AND:         h_nxt = 1'b1;
      OP_XOR, OP_OR:  ;
      OP_SHIFT:       c_nxt = sh_c;
      default: begin
        if (is_daa) begin
          n_nxt = req_q.n_in;
          c_nxt = req_q.daa_carry;
        end else begin
          // Reserved opcodes pass a through and leave every flag as it was.
          res_nxt = req_q.a;
          z_nxt   = fz;
          n_nxt   = fn;
          h_nxt   = fh;
          c_nxt   = fc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      req_q   <= '0;
      lo_q    <= 4'h0;
      hc_q    <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= 8'h00;
      fz      <= 1'b0;
      fn      <= 1'b0;
      fh      <= 1'b0;
      fc      <= 1'b0;
    end else begin
      state   <= state_nxt;
      valid_q <= hi;
      if (state == IDLE && bus.start) req_q <= req_d;
      if (state == LOW) begin
        lo_q <= nib;
        hc_q <= sl_cout;
      end
      if (hi) begin
        res_q <= res_nxt;
        fz    <= z_nxt;
        fn    <= n_nxt;
        fh    <= h_nxt;
        fc    <= c_nxt;
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.valid     = valid_q;
  assign bus.result    = res_q;
  assign bus.flag_z    = fz;
  assign bus.flag_n    = fn;
  assign bus.flag_h    = fh;
  assign bus.flag_c    = fc;
  assign bus.pri_carry = fc;
  assign bus.shift_dbh = bus.a[7];
  assign bus.shift_dbl = bus.a[0];
endmodule

// File: tb/tb_sm83_alu_nibble.sv
// Directed + randomized bench for sm83_alu_nibble against an arithmetic reference model.
module tb_sm83_alu_nibble;
  import sm83_alu_pkg::*;

  typedef struct {
    logic [7:0] res;
    logic z, n, h, c;
  } exp_t;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t mexp;

  sm83_alu_nibble_if bus();
  sm83_alu_nibble dut (.clk(clk), .nreset(nreset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: whole-byte integer arithmetic on the current bus inputs.
  function automatic exp_t model(input exp_t prev);
    exp_t e;
    int ai, bi, ci, d;
    e  = prev;
    ai = int'(bus.a);
    bi = int'(bus.b);
    ci = int'(bus.carry_in);
    case (bus.alu_op)
      4'd0, 4'd1: begin
        if (bus.alu_op == 4'd0) ci = 0;
        d = ai + bi + ci;
        e.res = 8'(d % 256);
        e.h = ((ai % 16) + (bi % 16) + ci) > 15;
        e.c = d > 255;
        e.n = 1'b0;
        e.z = (d % 256) == 0;
      end
      4'd2, 4'd3, 4'd7: begin
        if (bus.alu_op != 4'd3) ci = 0;
        d = ai - bi - ci;
        e.res = (bus.alu_op == 4'd7) ? bus.a : 8'((d + 256) % 256);
        e.h = (ai % 16) < ((bi % 16) + ci);
        e.c = d < 0;
        e.n = 1'b1;
        e.z = ((d + 256) % 256) == 0;
      end
      4'd4, 4'd5, 4'd6: begin
        e.res = (bus.alu_op == 4'd4) ? (bus.a & bus.b) :
                (bus.alu_op == 4'd5) ? (bus.a ^ bus.b) : (bus.a | bus.b);
        e.h = (bus.alu_op == 4'd4);
        e.c = 1'b0;
        e.n = 1'b0;
        e.z = (e.res == 8'h00);
      end
      4'd8: begin
        if (bus.shift_l) begin
          e.res = 8'((ai * 2 + int'(bus.shift_into_alu)) % 256);
          e.c = (ai / 128) == 1;
        end else if (bus.shift_r) begin
          e.res = 8'(ai / 2 + 128 * int'(bus.shift_into_alu));
          e.c = (ai % 2) == 1;
        end else begin
          e.res = bus.a;
          e.c = 1'b0;
        end
        e.h = 1'b0;
        e.n = 1'b0;
        e.z = (e.res == 8'h00);
      end
`ifdef SM83_ALU_DAA_EN
      4'd9: begin
        d = bus.n_in ? ai - int'(bus.daa_out) : ai + int'(bus.daa_out);
        e.res = 8'((d + 256) % 256);
        e.c = bus.daa_carry_out;
        e.h = 1'b0;
        e.n = bus.n_in;
        e.z = (e.res == 8'h00);
      end
`endif
      default: e.res = bus.a;
    endcase
    return e;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic sl, input logic sr, input logic si,
                       input logic [7:0] dv, input logic dc, input logic nin);
    bus.alu_op = op; bus.a = a; bus.b = b; bus.carry_in = ci;
    bus.shift_l = sl; bus.shift_r = sr; bus.shift_into_alu = si;
    bus.daa_out = dv; bus.daa_carry_out = dc; bus.n_in = nin;
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".res"}, 32'(bus.result), 32'(e.res));
    chk({tag, ".z"}, 32'(bus.flag_z), 32'(e.z));
    chk({tag, ".n"}, 32'(bus.flag_n), 32'(e.n));
    chk({tag, ".h"}, 32'(bus.flag_h), 32'(e.h));
    chk({tag, ".c"}, 32'(bus.flag_c), 32'(e.c));
    chk({tag, ".pc"}, 32'(bus.pri_carry), 32'(e.c));
  endtask

  task automatic comb_chk(input string tag);
    int ai;
    ai = int'(bus.a);
    chk({tag, ".dbh"}, 32'(bus.shift_dbh), 32'(ai / 128));
    chk({tag, ".dbl"}, 32'(bus.shift_dbl), 32'(ai % 2));
`ifdef SM83_ALU_DAA_EN
    chk({tag, ".lgt9"}, 32'(bus.daa_l_gt_9), 32'((ai % 16) > 9));
    chk({tag, ".hgt9"}, 32'(bus.daa_h_gt_9), 32'((ai / 16) > 9));
    chk({tag, ".heq9"}, 32'(bus.daa_h_eq_9), 32'((ai / 16) == 9));
`else
    chk({tag, ".lgt9"}, 32'(bus.daa_l_gt_9), 32'(0));
    chk({tag, ".hgt9"}, 32'(bus.daa_h_gt_9), 32'(0));
`endif
  endtask

  // Counts edges until valid is seen (99 if it never comes).
  task automatic wait_valid(output int n);
    n = 99;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (bus.valid) begin n = i; break; end
    end
  endtask

  task automatic run_op(input string tag);
    exp_t e;
    int n;
    e = model(mexp);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, ".busy"}, 32'(bus.busy), 32'(1));
    wait_valid(n);
    chk({tag, ".lat"}, 32'(n), 32'(2));
    check_out(tag, e);
    mexp = e;
    @(posedge clk); #1;
    chk({tag, ".vpulse"}, 32'(bus.valid), 32'(0));
  endtask

  initial begin
    exp_t e1, e2;
    int n;
    logic [7:0] adj [4];
    adj = '{8'h00, DAA_ADJ_L, DAA_ADJ_H, DAA_ADJ_L | DAA_ADJ_H};
    mexp.res = 8'h00; mexp.z = 1'b0; mexp.n = 1'b0; mexp.h = 1'b0; mexp.c = 1'b0;
    bus.start = 1'b0;
    drive(4'd0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);

    #2;
    chk("rst.busy", 32'(bus.busy), 32'(0));
    chk("rst.valid", 32'(bus.valid), 32'(0));
    check_out("rst", mexp);
    @(negedge clk); nreset = 1'b1;
    @(posedge clk); #1;

    drive(OP_ADD, 8'h3A, 8'hC6, 0, 0, 0, 0, 8'h00, 0, 0);
    run_op("add");
    drive(OP_SBC, 8'h10, 8'h01, 1, 0, 0, 0, 8'h00, 0, 0);
    run_op("sbc");
    drive(OP_CP, 8'h42, 8'h42, 0, 0, 0, 0, 8'h00, 0, 0);
    run_op("cp");
    drive(OP_SHIFT, 8'h01, 8'h00, 0, 0, 1, 1, 8'h00, 0, 0);
    run_op("shr");
    drive(OP_SHIFT, 8'h81, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);
    run_op("shl");
    drive(OP_AND, 8'hF0, 8'h0F, 0, 0, 0, 0, 8'h00, 0, 0);
    run_op("and");
    drive(4'd12, 8'h5A, 8'h11, 1, 0, 0, 0, 8'h00, 0, 0);
    run_op("rsv");
    drive(OP_DAA, 8'h9A, 8'h00, 0, 0, 0, 0, 8'h66, 1, 0);
    comb_chk("daa");
    run_op("daa");

    // start held through LOW and HIGH must not launch a second operation
    drive(OP_OR, 8'h12, 8'h30, 0, 0, 0, 0, 8'h00, 0, 0);
    e1 = model(mexp);
    bus.start = 1'b1;
    @(posedge clk); #1;
    drive(OP_AND, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    @(posedge clk); #1;
    chk("ign.busy", 32'(bus.busy), 32'(1));
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ign.valid", 32'(bus.valid), 32'(1));
    check_out("ign", e1);
    mexp = e1;
    @(posedge clk); #1;
    chk("ign.idle", 32'(bus.busy), 32'(0));
    chk("ign.nov", 32'(bus.valid), 32'(0));

    // back-to-back: start accepted in the valid cycle
    drive(OP_ADD, 8'h01, 8'h02, 0, 0, 0, 0, 8'h00, 0, 0);
    e1 = model(mexp);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_valid(n);
    chk("b2b1.lat", 32'(n), 32'(2));
    check_out("b2b1", e1);
    mexp = e1;
    drive(OP_XOR, 8'hF0, 8'hF0, 0, 0, 0, 0, 8'h00, 0, 0);
    e2 = model(mexp);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_valid(n);
    chk("b2b.gap", 32'(n + 1), 32'(3));
    check_out("b2b2", e2);
    mexp = e2;
    @(posedge clk); #1;

    // reset while in HIGH aborts without a valid pulse
    drive(OP_ADD, 8'h55, 8'h11, 0, 0, 0, 0, 8'h00, 0, 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b0;
    #1;
    mexp.res = 8'h00; mexp.z = 1'b0; mexp.n = 1'b0; mexp.h = 1'b0; mexp.c = 1'b0;
    chk("mrst.busy", 32'(bus.busy), 32'(0));
    chk("mrst.valid", 32'(bus.valid), 32'(0));
    check_out("mrst", mexp);
    @(negedge clk); nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mrst.nov", 32'(bus.valid), 32'(0));
    end
    drive(OP_SUB, 8'h20, 8'h21, 0, 0, 0, 0, 8'h00, 0, 0);
    run_op("post");

    for (int k = 0; k < 40; k++) begin
      drive(4'($urandom_range(0, 15)), 8'($urandom()), 8'($urandom()), 1'($urandom()),
            1'($urandom()), 1'($urandom()), 1'($urandom()), adj[$urandom_range(0, 3)],
            1'($urandom()), 1'($urandom()));
      comb_chk("rnd");
      run_op("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
